// File: rtl/router_fifo_n.sv
// Address router: steers each input word into one of NUM_OUT per-channel FIFOs by din_addr.
// Words with an out-of-range address are accepted, discarded and counted in a saturating drop_cnt.
module router_fifo_n #(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_OUT    = 4,
   parameter int DEPTH      = 4,
   parameter int ADDR_WIDTH = $clog2(NUM_OUT),
   parameter int CNT_WIDTH  = 8
) (
   input  logic                                 clk,
   input  logic                                 resetn,
   input  logic [DATA_WIDTH-1:0]                din,
   input  logic                                 din_valid,
   input  logic [ADDR_WIDTH-1:0]                din_addr,
   output logic                                 din_ready,
   output logic [NUM_OUT*DATA_WIDTH-1:0]        dout,
   output logic [NUM_OUT-1:0]                   dout_valid,
   input  logic [NUM_OUT-1:0]                   dout_ready,
   output logic [NUM_OUT*($clog2(DEPTH)+1)-1:0] fill,
   output logic [CNT_WIDTH-1:0]                 drop_cnt
);
   localparam int PW = $clog2(DEPTH);
   localparam int FW = PW + 1;

   logic [DATA_WIDTH-1:0] mem [NUM_OUT][DEPTH];
   logic [PW-1:0]         rd_ptr [NUM_OUT];
   logic [PW-1:0]         wr_ptr [NUM_OUT];
   logic [FW-1:0]         occ [NUM_OUT];
   logic [NUM_OUT-1:0]    push;
   logic [NUM_OUT-1:0]    pop;
   logic                  addr_ok;
   logic                  sel_full;
   logic                  accept;

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
      return (&v) ? v : v + CNT_WIDTH'(1);
   endfunction

   // Ready looks only at the addressed channel's registered occupancy, so a same-cycle pop
   // on a full channel does not open it up until the next cycle.
   always_comb begin
      addr_ok  = 1'b0;
      sel_full = 1'b0;
      push     = '0;
      pop      = '0;
      for (int k = 0; k < NUM_OUT; k++) begin
         if (din_addr == ADDR_WIDTH'(k)) begin
            addr_ok  = 1'b1;
            sel_full = (occ[k] == FW'(DEPTH));
         end
         pop[k] = (occ[k] != '0) && dout_ready[k];
      end
      din_ready = resetn && !sel_full;
      accept    = din_valid && din_ready;
      for (int k = 0; k < NUM_OUT; k++) begin
         push[k] = accept && addr_ok && (din_addr == ADDR_WIDTH'(k));
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         for (int k = 0; k < NUM_OUT; k++) begin
            rd_ptr[k] <= '0;
            wr_ptr[k] <= '0;
            occ[k]    <= '0;
         end
         drop_cnt <= '0;
      end else begin
         for (int k = 0; k < NUM_OUT; k++) begin
            if (push[k]) wr_ptr[k] <= wr_ptr[k] + PW'(1);
            if (pop[k])  rd_ptr[k] <= rd_ptr[k] + PW'(1);
            case ({push[k], pop[k]})
               2'b10:   occ[k] <= occ[k] + FW'(1);
               2'b01:   occ[k] <= occ[k] - FW'(1);
               default: ;
            endcase
         end
         if (accept && !addr_ok) drop_cnt <= sat_inc(drop_cnt);
      end
   end

   // Storage carries no reset; empty channels mask their head to zero instead.
   always_ff @(posedge clk) begin
      for (int k = 0; k < NUM_OUT; k++) begin
         if (push[k]) mem[k][wr_ptr[k]] <= din;
      end
   end

   for (genvar k = 0; k < NUM_OUT; k++) begin : g_out
      assign dout_valid[k]                   = (occ[k] != '0);
      assign dout[k*DATA_WIDTH +: DATA_WIDTH] = dout_valid[k] ? mem[k][rd_ptr[k]] : '0;
      assign fill[k*FW +: FW]                 = occ[k];
   end

endmodule

// File: tb/tb_router_fifo_n.sv
// Bench for router_fifo_n: queue-based reference model checked every cycle, plus directed
// scenarios with literal expectations; a second NUM_OUT=3 instance covers dropped words.
module tb_router_fifo_n;
   localparam int DW = 32;
   localparam int NO = 4;
   localparam int DP = 4;
   localparam int AW = 2;
   localparam int FW = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             resetn;
   logic [DW-1:0]    din;
   logic             din_valid;
   logic [AW-1:0]    din_addr;
   logic             din_ready;
   logic [NO*DW-1:0] dout;
   logic [NO-1:0]    dout_valid;
   logic [NO-1:0]    dout_ready;
   logic [NO*FW-1:0] fill;
   logic [7:0]       drop_cnt;

   logic [7:0]  din3;
   logic        din3_valid;
   logic [1:0]  din3_addr;
   logic        din3_ready;
   logic [23:0] dout3;
   logic [2:0]  dout3_valid;
   logic [2:0]  dout3_ready;
   logic [8:0]  fill3;
   logic [7:0]  drop3;

   router_fifo_n #(.DATA_WIDTH(DW), .NUM_OUT(NO), .DEPTH(DP), .ADDR_WIDTH(AW), .CNT_WIDTH(8)) u_dut (
      .clk(clk), .resetn(resetn), .din(din), .din_valid(din_valid), .din_addr(din_addr),
      .din_ready(din_ready), .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
      .fill(fill), .drop_cnt(drop_cnt));

   router_fifo_n #(.DATA_WIDTH(8), .NUM_OUT(3), .DEPTH(4), .ADDR_WIDTH(2), .CNT_WIDTH(8)) u_dut3 (
      .clk(clk), .resetn(resetn), .din(din3), .din_valid(din3_valid), .din_addr(din3_addr),
      .din_ready(din3_ready), .dout(dout3), .dout_valid(dout3_valid), .dout_ready(dout3_ready),
      .fill(fill3), .drop_cnt(drop3));

   int nvec  = 0;
   int nfail = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: one queue per channel plus a saturating drop count.
   logic [DW-1:0] mq [NO][$];
   int            m_drop = 0;
   bit            m_acc;

   always @(posedge clk) begin
      if (!resetn) begin
         for (int k = 0; k < NO; k++) mq[k].delete();
         m_drop = 0;
      end else begin
         m_acc = din_valid && ((int'(din_addr) >= NO) || (mq[din_addr].size() < DP));
         for (int k = 0; k < NO; k++) begin
            if (dout_ready[k] && mq[k].size() > 0) void'(mq[k].pop_front());
         end
         if (m_acc) begin
            if (int'(din_addr) < NO) mq[din_addr].push_back(din);
            else if (m_drop < 255) m_drop++;
         end
      end
      #1;
      check("din_ready", din_ready,
            (resetn && ((int'(din_addr) >= NO) || (mq[din_addr].size() < DP))) ? 64'd1 : 64'd0);
      for (int k = 0; k < NO; k++) begin
         check("dout_valid", dout_valid[k], (mq[k].size() != 0) ? 64'd1 : 64'd0);
         check("dout", dout[k*DW +: DW], (mq[k].size() != 0) ? 64'(mq[k][0]) : 64'd0);
         check("fill", fill[k*FW +: FW], 64'(mq[k].size()));
      end
      check("drop_cnt", drop_cnt, 64'(m_drop));
   end

   task automatic drive(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
      din_valid = v;
      din_addr  = a;
      din       = d;
   endtask

   initial begin
      resetn = 1'b0; din = '0; din_valid = 1'b0; din_addr = '0; dout_ready = '0;
      din3 = '0; din3_valid = 1'b0; din3_addr = '0; dout3_ready = '0;
      repeat (3) @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);

      // Idle after reset
      check("idle_valid", dout_valid, 64'h0);
      check("idle_dout_zero", (dout == '0) ? 64'd1 : 64'd0, 64'd1);
      check("idle_fill", fill, 64'h0);
      check("idle_drop", drop_cnt, 64'h0);
      for (int a = 0; a < NO; a++) begin
         din_addr = AW'(a);
         #1;
         check("idle_ready", din_ready, 64'd1);
      end

      // Three words to channel 2, then drain in order
      @(negedge clk); drive(1'b1, 2'd2, 32'hA0);
      @(negedge clk); drive(1'b1, 2'd2, 32'hA1);
      check("ch2_valid_latency", dout_valid, 64'b0100);
      check("ch2_head_a0", dout[2*DW +: DW], 64'hA0);
      @(negedge clk); drive(1'b1, 2'd2, 32'hA2);
      @(negedge clk); drive(1'b0, 2'd2, 32'h0);
      check("ch2_fill3", fill[2*FW +: FW], 64'd3);
      check("ch2_pop0", dout[2*DW +: DW], 64'hA0);
      dout_ready = 4'b0100;
      @(negedge clk); check("ch2_pop1", dout[2*DW +: DW], 64'hA1);
      @(negedge clk); check("ch2_pop2", dout[2*DW +: DW], 64'hA2);
      @(negedge clk); dout_ready = 4'b0000;
      check("ch2_empty_dout", dout[2*DW +: DW], 64'h0);
      check("ch2_empty_valid", dout_valid, 64'h0);

      // Fill channel 1; other channels remain open
      for (int i = 0; i < DP; i++) begin
         @(negedge clk); drive(1'b1, 2'd1, 32'hB0 + 32'(i));
      end
      @(negedge clk); drive(1'b0, 2'd1, 32'h0);
      #1; check("full_ch1_ready", din_ready, 64'd0);
      din_addr = 2'd0;
      #1; check("ch0_ready_while_ch1_full", din_ready, 64'd1);
      drive(1'b1, 2'd0, 32'hC0);
      @(negedge clk); drive(1'b0, 2'd1, 32'h0); dout_ready = 4'b0010;
      #1; check("full_pop_same_cycle_ready", din_ready, 64'd0);
      @(negedge clk); dout_ready = 4'b0000;
      #1; check("after_pop_ready", din_ready, 64'd1);
      check("ch1_fill_after_pop", fill[1*FW +: FW], 64'd3);
      check("ch0_head_c0", dout[0 +: DW], 64'hC0);
      check("ch1_head_b1", dout[1*DW +: DW], 64'hB1);
      dout_ready = 4'b0011;
      repeat (4) @(negedge clk);
      dout_ready = 4'b0000;
      check("drain_valid", dout_valid, 64'h0);

      // Steady push+pop on channel 3 across pointer wrap
      @(negedge clk); drive(1'b1, 2'd3, 32'hDEAD0000);
      @(negedge clk); dout_ready = 4'b1000;
      for (int i = 0; i < 3*DP; i++) begin
         drive(1'b1, 2'd3, 32'hD0 + 32'(i % 7));
         #1;
         check("stream_fill", fill[3*FW +: FW], 64'd1);
         check("stream_head", dout[3*DW +: DW], (i == 0) ? 64'hDEAD0000 : 64'(32'hD0 + 32'((i-1) % 7)));
         @(negedge clk);
      end
      drive(1'b0, 2'd3, 32'h0);
      check("stream_last", dout[3*DW +: DW], 64'hD4);
      @(negedge clk); dout_ready = 4'b0000;
      check("stream_empty", dout_valid, 64'h0);

      // NUM_OUT=3 instance: out-of-range words always accepted and counted, saturating
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         din3_valid = 1'b1; din3_addr = 2'd3; din3 = 8'(i);
         #1;
         check("n3_ready", din3_ready, 64'd1);
         check("n3_no_valid", dout3_valid, 64'd0);
         if (i == 100) check("n3_drop_100", drop3, 64'd100);
      end
      @(negedge clk); din3_valid = 1'b0;
      check("n3_drop_sat", drop3, 64'd255);
      check("n3_fill", fill3, 64'd0);
      check("n3_dout", dout3, 64'd0);

      // Reset with channels 0 and 2 half full
      @(negedge clk); drive(1'b1, 2'd0, 32'hE0);
      @(negedge clk); drive(1'b1, 2'd0, 32'hE1);
      @(negedge clk); drive(1'b1, 2'd2, 32'hF0);
      @(negedge clk); drive(1'b1, 2'd2, 32'hF1);
      @(negedge clk);
      check("pre_rst_fill0", fill[0 +: FW], 64'd2);
      check("pre_rst_fill2", fill[2*FW +: FW], 64'd2);
      resetn = 1'b0; drive(1'b1, 2'd0, 32'h99);
      #1; check("rst_ready_low", din_ready, 64'd0);
      @(negedge clk); resetn = 1'b1; drive(1'b0, 2'd0, 32'h0);
      check("rst_valid", dout_valid, 64'h0);
      check("rst_fill", fill, 64'h0);
      check("rst_dout_zero", (dout == '0) ? 64'd1 : 64'd0, 64'd1);
      drive(1'b1, 2'd0, 32'h77);
      @(negedge clk); drive(1'b0, 2'd0, 32'h0);
      check("post_rst_valid", dout_valid, 64'b0001);
      check("post_rst_head", dout[0 +: DW], 64'h77);
      check("post_rst_fill", fill[0 +: FW], 64'd1);

      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
